spm_dma: RTL and testbench
==========================

# spm_dma

Programmable block-transfer engine that acts as the initiator on the scratch-pad memory access port (`if_spm_*`). It fills, copies or verifies a contiguous range of SPM words without CPU involvement. It sits beside the SPM on the same port the CPU pipeline uses; arbitration is outside this block. Control is a start/busy/done handshake driven by a register bank or a test harness.

## Interface
Parameters:
- `SPM_ADDR_W`, default 12: SPM word-address width (`SpmAddrBus`).
- `DATA_W`, default 32: word width (`WordDataBus`).

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `mode` in 2: 0 FILL, 1 COPY, 2 CHECK, 3 reserved (treated as len=0).
- `src_addr` in SPM_ADDR_W: COPY source / CHECK base.
- `dst_addr` in SPM_ADDR_W: FILL / COPY destination.
- `len` in SPM_ADDR_W+1: word count, 0..2^SPM_ADDR_W.
- `pattern` in DATA_W: FILL/CHECK base value.
- `step` in DATA_W: per-word increment; expected word i = pattern + i*step mod 2^DATA_W.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle completion pulse.
- `err_cnt` out SPM_ADDR_W+1: CHECK mismatch count.
- `first_err_addr` out SPM_ADDR_W: address of first CHECK mismatch.
- `if_spm_addr` out SPM_ADDR_W: SPM address.
- `if_spm_as_` out 1: address strobe, active-low (`ENABLE_`/`DISABLE_`).
- `if_spm_rw` out 1: `READ`/`WRITE`.
- `if_spm_wr_data` out DATA_W: write data.
- `if_spm_rd_data` in DATA_W: read data, valid the cycle after a read access cycle.

## Operation
- All outputs are registered. Reset values:
  - `busy`=0, `done`=0.
  - `err_cnt`=0, `first_err_addr`=0.
  - `if_spm_as_`=`DISABLE_`, `if_spm_rw`=`READ`, `if_spm_addr`=0, `if_spm_wr_data`=0.
- States: IDLE, FILL, COPY_RD, COPY_WR, CHK_RD, CHK_LAST, DONE.
- Start acceptance:
  - In IDLE, `start`=1 latches all control inputs, clears `err_cnt`/`first_err_addr`, and loads word index i=0.
  - `len`=0 or `mode`=3 goes directly to DONE.
- FILL: one write per cycle, addr=dst+i, data=pattern+i*step. After word len-1, go to DONE.
- COPY, two cycles per word:
  - COPY_RD: read src+i.
  - COPY_WR: write dst+i with the `if_spm_rd_data` captured this cycle.
  - Forward order. An overlapping range with src<dst replicates source data; this is the defined behaviour.
- CHECK:
  - One read per cycle at src+i.
  - The word returned in the following cycle is compared with its expected value.
  - On a mismatch, `err_cnt` increments. `first_err_addr` is loaded only on the first mismatch.
  - After the last read, CHK_LAST performs the final compare, then the FSM goes to DONE.
- Addresses wrap modulo 2^SPM_ADDR_W. The running value pattern+i*step is kept with an accumulator adder, not a multiplier.
- DONE: `done`=1 for one cycle, `busy`=0, then the FSM returns to IDLE.
- `start` while not in IDLE is ignored; no queuing.
- `if_spm_as_`=`DISABLE_` in every cycle without an access. `if_spm_wr_data` holds its last value when idle.
- Asserting `rst_n` low mid-operation aborts immediately to the reset values. Partially written memory is not restored.

## Timing
- Cycle 0: `start` sampled. Cycle 1: first access (or DONE if len=0).
- `busy`=1 from cycle 1 through the last non-DONE cycle. It is low in the `done` cycle.
- `done` cycle, for len=N>0:
  - FILL: cycle N+1.
  - COPY: cycle 2N+1.
  - CHECK: cycle N+2.
  - len=0: cycle 1.
- `err_cnt` and `first_err_addr` are final and stable in the `done` cycle and hold until the next accepted start.
- The earliest next `start` acceptance is the cycle after `done`.

## Test plan
- FILL dst=0, len=16, pattern=255, step=0xFFFFFFFF -> SPM[i]=255-i for i=0..15; `done` at cycle 17; exactly 16 cycles with `as_` enabled, all with rw=`WRITE`.
- COPY src=0, dst=0x100, len=16 after the fill above -> SPM[0x100+i]=255-i; 32 access cycles alternating READ/WRITE; `done` at cycle 33.
- CHECK src=0, len=16, pattern=255, step=-1 with SPM[5] corrupted to 0 -> `err_cnt`=1, `first_err_addr`=5, `done` at cycle 18. With no corruption -> `err_cnt`=0.
- Wrap: FILL dst=0xFFE, len=4, pattern=1, step=1 -> writes to addresses 0xFFE, 0xFFF, 0x000, 0x001 with data 1..4.
- len=0 -> `done` in cycle 1, no `as_` enabled. `start` pulsed while busy -> ignored, and the original operation's results are unchanged.
- `rst_n` pulsed low at cycle 5 of a len=16 FILL -> all outputs return to their reset values asynchronously, no further writes, and the FSM is in IDLE.

Source files
------------

// File: rtl/spm_dma.sv
// Block-transfer engine on the SPM access port: fills, copies or verifies a word range.
// Read data is sampled on the rising edge that closes the read access cycle.
module spm_dma #(
  parameter int SPM_ADDR_W = 12,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [SPM_ADDR_W-1:0] src_addr,
  input  logic [SPM_ADDR_W-1:0] dst_addr,
  input  logic [SPM_ADDR_W:0]   len,
  input  logic [DATA_W-1:0]     pattern,
  input  logic [DATA_W-1:0]     step,
  output logic                  busy,
  output logic                  done,
  output logic [SPM_ADDR_W:0]   err_cnt,
  output logic [SPM_ADDR_W-1:0] first_err_addr,
  output logic [SPM_ADDR_W-1:0] if_spm_addr,
  output logic                  if_spm_as_,
  output logic                  if_spm_rw,
  output logic [DATA_W-1:0]     if_spm_wr_data,
  input  logic [DATA_W-1:0]     if_spm_rd_data
);

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;

  typedef enum logic [2:0] {IDLE, FILL, COPY_RD, COPY_WR, CHK_RD, CHK_LAST, DONE} state_e;
  typedef enum logic [1:0] {MODE_FILL, MODE_COPY, MODE_CHECK, MODE_RSVD} mode_e;

  state_e                state;
  logic [SPM_ADDR_W-1:0] src_q, dst_q, cmp_addr;
  logic [SPM_ADDR_W:0]   len_q, idx, idx_nxt;
  logic [DATA_W-1:0]     step_q, acc, acc_nxt, rd_q, exp_q;
  logic                  cmp_vld, last, mismatch;

  always_comb begin
    idx_nxt  = idx + (SPM_ADDR_W+1)'(1);
    acc_nxt  = acc + step_q;
    last     = (idx == len_q - (SPM_ADDR_W+1)'(1));
    mismatch = cmp_vld && (rd_q != exp_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      if_spm_addr    <= '0;
      if_spm_as_     <= DISABLE_;
      if_spm_rw      <= READ;
      if_spm_wr_data <= '0;
      src_q          <= '0;
      dst_q          <= '0;
      len_q          <= '0;
      idx            <= '0;
      step_q         <= '0;
      acc            <= '0;
      rd_q           <= '0;
      exp_q          <= '0;
      cmp_addr       <= '0;
      cmp_vld        <= 1'b0;
    end else begin
      done    <= 1'b0;
      cmp_vld <= 1'b0;
      // Compare is one cycle behind the read that fetched the word
      if (mismatch) begin
        err_cnt <= err_cnt + (SPM_ADDR_W+1)'(1);
        if (err_cnt == '0) first_err_addr <= cmp_addr;
      end
      unique case (state)
        IDLE: if (start) begin
          src_q          <= src_addr;
          dst_q          <= dst_addr;
          len_q          <= len;
          step_q         <= step;
          acc            <= pattern;
          idx            <= '0;
          err_cnt        <= '0;
          first_err_addr <= '0;
          if (len == '0 || mode_e'(mode) == MODE_RSVD) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            busy       <= 1'b1;
            if_spm_as_ <= ENABLE_;
            case (mode_e'(mode))
              MODE_FILL: begin
                state          <= FILL;
                if_spm_rw      <= WRITE;
                if_spm_addr    <= dst_addr;
                if_spm_wr_data <= pattern;
              end
              MODE_COPY: begin
                state       <= COPY_RD;
                if_spm_rw   <= READ;
                if_spm_addr <= src_addr;
              end
              default: begin
                state       <= CHK_RD;
                if_spm_rw   <= READ;
                if_spm_addr <= src_addr;
              end
            endcase
          end
        end
        FILL: begin
          if (last) begin
            if_spm_as_ <= DISABLE_;
            if_spm_rw  <= READ;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            idx            <= idx_nxt;
            acc            <= acc_nxt;
            if_spm_addr    <= if_spm_addr + SPM_ADDR_W'(1);
            if_spm_wr_data <= acc_nxt;
          end
        end
        COPY_RD: begin
          if_spm_rw      <= WRITE;
          if_spm_addr    <= dst_q + idx[SPM_ADDR_W-1:0];
          if_spm_wr_data <= if_spm_rd_data;
          state          <= COPY_WR;
        end
        COPY_WR: begin
          if (last) begin
            if_spm_as_ <= DISABLE_;
            if_spm_rw  <= READ;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            idx         <= idx_nxt;
            if_spm_rw   <= READ;
            if_spm_addr <= src_q + idx_nxt[SPM_ADDR_W-1:0];
            state       <= COPY_RD;
          end
        end
        CHK_RD: begin
          rd_q     <= if_spm_rd_data;
          exp_q    <= acc;
          cmp_addr <= if_spm_addr;
          cmp_vld  <= 1'b1;
          acc      <= acc_nxt;
          if (last) begin
            if_spm_as_ <= DISABLE_;
            state      <= CHK_LAST;
          end else begin
            idx         <= idx_nxt;
            if_spm_addr <= if_spm_addr + SPM_ADDR_W'(1);
          end
        end
        CHK_LAST: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spm_dma.sv
// Directed bench for spm_dma: a behavioural SPM plus hand-computed expectations.
module tb_spm_dma;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = '0;
  logic [AW-1:0] src_addr = '0, dst_addr = '0;
  logic [AW:0]   len = '0;
  logic [DW-1:0] pattern = '0, step = '0;
  logic          busy, done;
  logic [AW:0]   err_cnt;
  logic [AW-1:0] first_err_addr, if_spm_addr;
  logic          if_spm_as_, if_spm_rw;
  logic [DW-1:0] if_spm_wr_data;
  logic [DW-1:0] if_spm_rd_data = '0;

  logic [DW-1:0] mem [4096];
  int tests = 0, fails = 0;
  int done_cyc, n_acc, n_wr, busy_bad, alt_bad, idle_bad;

  spm_dma #(.SPM_ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .pattern(pattern), .step(step), .busy(busy), .done(done),
    .err_cnt(err_cnt), .first_err_addr(first_err_addr),
    .if_spm_addr(if_spm_addr), .if_spm_as_(if_spm_as_), .if_spm_rw(if_spm_rw),
    .if_spm_wr_data(if_spm_wr_data), .if_spm_rd_data(if_spm_rd_data)
  );

  always #5 clk = ~clk;

  // SPM model clocked mid-cycle, so read data is ready at the next rising edge
  always @(negedge clk) begin
    if (if_spm_as_ == 1'b0) begin
      if (if_spm_rw) if_spm_rd_data <= mem[if_spm_addr];
      else           mem[if_spm_addr] = if_spm_wr_data;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                        input logic [AW:0] l, input logic [DW-1:0] p, input logic [DW-1:0] st,
                        input int pulse_at);
    @(negedge clk);
    mode = m; src_addr = s; dst_addr = d; len = l; pattern = p; step = st; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_cyc = 0; n_acc = 0; n_wr = 0; busy_bad = 0; alt_bad = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == pulse_at) begin
        mode = 2'd0; dst_addr = 12'h300; len = 13'd4; start = 1'b1;
      end
      if (done) begin
        done_cyc = k;
        if (busy) busy_bad++;
        if (!if_spm_as_) n_acc++;
        break;
      end
      if (!busy) busy_bad++;
      if (!if_spm_as_) begin
        n_acc++;
        if (!if_spm_rw) n_wr++;
        if ((m == 2'd1) && (if_spm_rw != ((n_acc % 2) == 1))) alt_bad++;
      end
    end
    start = 1'b0;
  endtask

  task automatic idle_watch(input int cycles);
    idle_bad = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (!if_spm_as_ || done || busy) idle_bad++;
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_ctl", {busy, done, if_spm_as_, if_spm_rw}, 4'b0011);
    check("reset_regs", {err_cnt, first_err_addr, if_spm_addr}, '0);
    check("reset_wdata", if_spm_wr_data, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // FILL 255 descending
    run_op(2'd0, 12'h000, 12'h000, 13'd16, 32'd255, 32'hFFFF_FFFF, 0);
    check("fill_done_cyc", done_cyc, 17);
    check("fill_acc", n_acc, 16);
    check("fill_wr", n_wr, 16);
    check("fill_busy", busy_bad, 0);
    for (int i = 0; i < 16; i++) check("fill_mem", mem[i], 255 - i);
    idle_watch(3);
    check("fill_wdata_hold", if_spm_wr_data, 240);

    // COPY to 0x100
    run_op(2'd1, 12'h000, 12'h100, 13'd16, 32'd0, 32'd0, 0);
    check("copy_done_cyc", done_cyc, 33);
    check("copy_acc", n_acc, 32);
    check("copy_alt", alt_bad, 0);
    check("copy_busy", busy_bad, 0);
    for (int i = 0; i < 16; i++) check("copy_mem", mem[12'h100 + i], 255 - i);

    // CHECK clean, one corruption, two corruptions
    run_op(2'd2, 12'h000, 12'h000, 13'd16, 32'd255, 32'hFFFF_FFFF, 0);
    check("chk_clean_cyc", done_cyc, 18);
    check("chk_clean_err", err_cnt, 0);
    check("chk_clean_busy", busy_bad, 0);
    mem[5] = '0;
    run_op(2'd2, 12'h000, 12'h000, 13'd16, 32'd255, 32'hFFFF_FFFF, 0);
    check("chk1_cyc", done_cyc, 18);
    check("chk1_err", err_cnt, 1);
    check("chk1_first", first_err_addr, 5);
    mem[9] = '0;
    run_op(2'd2, 12'h000, 12'h000, 13'd16, 32'd255, 32'hFFFF_FFFF, 0);
    check("chk2_err", err_cnt, 2);
    check("chk2_first", first_err_addr, 5);

    // start pulsed mid-CHECK must be ignored
    mem[9] = 32'd246;
    run_op(2'd2, 12'h000, 12'h000, 13'd16, 32'd255, 32'hFFFF_FFFF, 4);
    check("busy_start_cyc", done_cyc, 18);
    check("busy_start_err", err_cnt, 1);
    check("busy_start_first", first_err_addr, 5);
    check("busy_start_wr", n_wr, 0);
    idle_watch(6);
    check("busy_start_idle", idle_bad, 0);
    check("err_hold", err_cnt, 1);
    check("busy_start_mem", mem[12'h300], 0);

    // address wrap
    run_op(2'd0, 12'h000, 12'hFFE, 13'd4, 32'd1, 32'd1, 0);
    check("wrap_cyc", done_cyc, 5);
    check("wrap_ffe", mem[12'hFFE], 1);
    check("wrap_fff", mem[12'hFFF], 2);
    check("wrap_000", mem[0], 3);
    check("wrap_001", mem[1], 4);
    check("wrap_002", mem[2], 253);
    check("wrap_ffd", mem[12'hFFD], 0);

    // len=0 and reserved mode
    run_op(2'd2, 12'h000, 12'h000, 13'd0, 32'd0, 32'd0, 0);
    check("len0_cyc", done_cyc, 1);
    check("len0_acc", n_acc, 0);
    check("len0_err_clr", err_cnt, 0);
    run_op(2'd3, 12'h000, 12'h000, 13'd5, 32'd0, 32'd0, 0);
    check("rsvd_cyc", done_cyc, 1);
    check("rsvd_acc", n_acc, 0);

    // reset in cycle 5 of a FILL
    for (int i = 0; i < 16; i++) mem[12'h200 + i] = 32'hDEAD;
    @(negedge clk);
    mode = 2'd0; dst_addr = 12'h200; len = 13'd16; pattern = 32'd7; step = 32'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ctl", {busy, done, if_spm_as_, if_spm_rw}, 4'b0011);
    check("abort_regs", {err_cnt, first_err_addr, if_spm_addr}, '0);
    check("abort_wdata", if_spm_wr_data, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_watch(5);
    check("abort_idle", idle_bad, 0);
    check("abort_mem203", mem[12'h203], 10);
    check("abort_mem204", mem[12'h204], 32'hDEAD);
    check("abort_mem20f", mem[12'h20F], 32'hDEAD);
    run_op(2'd0, 12'h000, 12'h000, 13'd0, 32'd0, 32'd0, 0);
    check("abort_then_len0", done_cyc, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
